// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the neuron layer sequencer.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    ACT,
    EMIT,
    DONE
  } state_t;

  // Address/index width that stays legal when the count is 1.
  function automatic int nn_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that times the fixed pipeline waits of the sequencer.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over count; the count holds once it reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Per-neuron sequencer for one fully-connected layer: clear, accumulate,
// drain, activate, then hand the result index downstream.
module neuron_layer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int MAC_LAT     = 2,
  parameter int ACT_LAT     = 1,
  parameter int IA_W        = nn_width(NUM_INPUTS),
  parameter int NI_W        = nn_width(NUM_NEURONS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            relu_sel,
  output logic            busy,
  output logic            done,
  output logic [IA_W-1:0] in_addr,
  output logic [NI_W-1:0] neuron_idx,
  output logic            acc_clr,
  output logic            acc_en,
  output logic            act_en,
  output logic            activation_function,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NI_W-1:0] out_idx
);

  localparam int MAX_LAT = (MAC_LAT > ACT_LAT) ? MAC_LAT : ACT_LAT;
  localparam int CW      = nn_width(MAX_LAT);

  localparam logic [CW-1:0]   DRAIN_LOAD  = CW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [CW-1:0]   ACT_LOAD    = CW'(ACT_LAT - 1);
  localparam logic [IA_W-1:0] LAST_ADDR   = IA_W'(NUM_INPUTS - 1);
  localparam logic [NI_W-1:0] LAST_NEURON = NI_W'(NUM_NEURONS - 1);

  state_t          state;
  logic            last_addr;
  logic            cnt_load;
  logic            cnt_en;
  logic [CW-1:0]   cnt_val;
  logic            cnt_zero;

  assign last_addr = (in_addr == LAST_ADDR);

  // One counter covers both waits: loaded on ACCUM exit and again on DRAIN exit.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = ACT_LOAD;
    if (state == ACCUM && last_addr) begin
      cnt_load = 1'b1;
      cnt_val  = (MAC_LAT > 0) ? DRAIN_LOAD : ACT_LOAD;
    end else if (state == DRAIN && cnt_zero) begin
      cnt_load = 1'b1;
    end
  end

  assign cnt_en = (state == DRAIN) || (state == ACT);

  lat_counter #(
    .W(CW)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Result handshake: out_valid rises with out_idx in EMIT and both hold until
  // the cycle out_ready is also high; out_ready is ignored while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      busy                <= 1'b0;
      done                <= 1'b0;
      in_addr             <= '0;
      neuron_idx          <= '0;
      acc_clr             <= 1'b0;
      acc_en              <= 1'b0;
      act_en              <= 1'b0;
      activation_function <= 1'b0;
      out_valid           <= 1'b0;
      out_idx             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state               <= CLEAR;
            busy                <= 1'b1;
            activation_function <= relu_sel;
            neuron_idx          <= '0;
            in_addr             <= '0;
            acc_clr             <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= ACCUM;
          acc_clr <= 1'b0;
          acc_en  <= 1'b1;
        end
        ACCUM: begin
          if (last_addr) begin
            acc_en <= 1'b0;
            if (MAC_LAT > 0) begin
              state <= DRAIN;
            end else begin
              state  <= ACT;
              act_en <= 1'b1;
            end
          end else begin
            in_addr <= in_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_zero) begin
            state  <= ACT;
            act_en <= 1'b1;
          end
        end
        ACT: begin
          act_en <= 1'b0;
          if (cnt_zero) begin
            state     <= EMIT;
            out_valid <= 1'b1;
            out_idx   <= neuron_idx;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neuron_idx == LAST_NEURON) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= CLEAR;
              neuron_idx <= neuron_idx + 1'b1;
              in_addr    <= '0;
              acc_clr    <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench: a 4-input/3-neuron instance for the main scenarios and a
// 1-input/1-neuron, MAC_LAT=0 instance for the degenerate corner.
module tb_neuron_layer_ctrl;

  logic clk;
  logic rst;

  // Main instance: NUM_INPUTS=4, NUM_NEURONS=3, MAC_LAT=2, ACT_LAT=1.
  logic       start, relu_sel, out_ready;
  logic       busy, done, acc_clr, acc_en, act_en, activation_function, out_valid;
  logic [1:0] in_addr, neuron_idx, out_idx;

  // Corner instance: NUM_INPUTS=1, NUM_NEURONS=1, MAC_LAT=0, ACT_LAT=1.
  logic c_start, c_relu_sel, c_out_ready;
  logic c_busy, c_done, c_acc_clr, c_acc_en, c_act_en, c_activation_function, c_out_valid;
  logic [0:0] c_in_addr, c_neuron_idx, c_out_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  neuron_layer_ctrl #(
    .NUM_INPUTS(4), .NUM_NEURONS(3), .MAC_LAT(2), .ACT_LAT(1)
  ) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .relu_sel            (relu_sel),
    .busy                (busy),
    .done                (done),
    .in_addr             (in_addr),
    .neuron_idx          (neuron_idx),
    .acc_clr             (acc_clr),
    .acc_en              (acc_en),
    .act_en              (act_en),
    .activation_function (activation_function),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_idx             (out_idx)
  );

  neuron_layer_ctrl #(
    .NUM_INPUTS(1), .NUM_NEURONS(1), .MAC_LAT(0), .ACT_LAT(1)
  ) u_dut_c (
    .clk                 (clk),
    .rst                 (rst),
    .start               (c_start),
    .relu_sel            (c_relu_sel),
    .busy                (c_busy),
    .done                (c_done),
    .in_addr             (c_in_addr),
    .neuron_idx          (c_neuron_idx),
    .acc_clr             (c_acc_clr),
    .acc_en              (c_acc_en),
    .act_en              (c_act_en),
    .activation_function (c_activation_function),
    .out_valid           (c_out_valid),
    .out_ready           (c_out_ready),
    .out_idx             (c_out_idx)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] main_ctrl();
    return {busy, done, acc_clr, acc_en, act_en, out_valid};
  endfunction

  function automatic logic [5:0] corner_ctrl();
    return {c_busy, c_done, c_acc_clr, c_acc_en, c_act_en, c_out_valid};
  endfunction

  // Expected strobes for the main instance in cycle c after an accepted start,
  // with out_ready held low for s cycles at the first EMIT. Per neuron (9 cycles):
  // CLEAR, ACCUM x4, DRAIN x2, ACT, EMIT; DONE in cycle 28 (unstalled).
  // Bit order {busy, done, acc_clr, acc_en, act_en, out_valid}.
  function automatic void exp_main(input int c_in, input int s, output logic [5:0] ctrl,
                                   output int addr, output int nidx);
    int c;
    int p;
    c = c_in;
    if (c > 9 && c <= 9 + s) c = 9;
    else if (c > 9 + s) c = c - s;
    ctrl = 6'b000000;
    addr = -1;
    nidx = -1;
    if (c == 28) begin
      ctrl = 6'b110000;
    end else if (c >= 1 && c < 28) begin
      p    = (c - 1) % 9;
      nidx = (c - 1) / 9;
      if (p == 0) begin
        ctrl = 6'b101000;
        addr = 0;
      end else if (p <= 4) begin
        ctrl = 6'b100100;
        addr = p - 1;
      end else if (p <= 6) begin
        ctrl = 6'b100000;
      end else if (p == 7) begin
        ctrl = 6'b100010;
      end else begin
        ctrl = 6'b100001;
      end
    end
  endfunction

  // Runs one layer on the main instance; called right after a tick, with the
  // block in IDLE. Start is re-pulsed in ACCUM (c=3) and optionally in DONE.
  task automatic run_layer(input int s, input bit relu0, input bit dup_done_start,
                           input int ncyc);
    logic [5:0] ctrl;
    int addr;
    int nidx;
    start    = 1'b1;
    relu_sel = relu0;
    for (int n = 0; n < 3; n++) exp_q.push_back(n);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      exp_main(c, s, ctrl, addr, nidx);
      check("ctrl", {26'd0, main_ctrl()}, {26'd0, ctrl});
      if (addr >= 0) check("in_addr", {30'd0, in_addr}, addr);
      if (nidx >= 0) check("neuron_idx", {30'd0, neuron_idx}, nidx);
      check("act_fn", {31'd0, activation_function}, {31'd0, relu0});
      start = 1'b0;
      if (c == 3) begin
        start    = 1'b1;
        relu_sel = ~relu0;
      end
      if (dup_done_start && c == 28 + s) start = 1'b1;
      out_ready = !(c >= 9 && c < 9 + s);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
        else check("out_idx", {30'd0, out_idx}, exp_q.pop_front());
      end
    end
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  logic [5:0] corner_exp [6];
  logic [5:0] ctrl_v;
  int addr_v;
  int nidx_v;

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    relu_sel    = 1'b0;
    out_ready   = 1'b1;
    c_start     = 1'b0;
    c_relu_sel  = 1'b0;
    c_out_ready = 1'b1;

    // Reset state, with start asserted to show reset dominates.
    tick();
    start   = 1'b1;
    c_start = 1'b1;
    tick();
    tick();
    check("rst_ctrl", {26'd0, main_ctrl()}, 32'd0);
    check("rst_idx", {26'd0, in_addr, neuron_idx, out_idx}, 32'd0);
    check("rst_act_fn", {31'd0, activation_function}, 32'd0);
    check("rst_c_ctrl", {26'd0, corner_ctrl()}, 32'd0);
    start   = 1'b0;
    c_start = 1'b0;
    rst     = 1'b0;
    tick();
    tick();
    check("idle_after_rst", {26'd0, main_ctrl()}, 32'd0);

    // Layer 1: no backpressure, ReLU off, start in ACCUM and DONE ignored.
    run_layer(0, 1'b0, 1'b1, 31);

    // Layer 2: 5-cycle stall at first EMIT, ReLU on and toggled mid-ACCUM;
    // start raised in DONE and held into the next IDLE cycle.
    run_layer(5, 1'b1, 1'b1, 34);

    // Layer 3 starts from that held start; reset hits during DRAIN of neuron 1.
    start    = 1'b1;
    relu_sel = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
      exp_main(c, 0, ctrl_v, addr_v, nidx_v);
      check("l3_ctrl", {26'd0, main_ctrl()}, {26'd0, ctrl_v});
      if (addr_v >= 0) check("l3_in_addr", {30'd0, in_addr}, addr_v);
      if (c == 9) check("l3_out_idx", {30'd0, out_idx}, 32'd0);
    end
    check("l3_drain_neuron", {30'd0, neuron_idx}, 32'd1);
    check("l3_act_fn", {31'd0, activation_function}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {26'd0, main_ctrl()}, 32'd0);
    check("async_rst_idx", {26'd0, in_addr, neuron_idx, out_idx}, 32'd0);
    check("async_rst_act_fn", {31'd0, activation_function}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_idle", {26'd0, main_ctrl()}, 32'd0);
    end

    // Corner instance: CLEAR, one ACCUM, ACT, EMIT, DONE, IDLE.
    corner_exp[0] = 6'b101000;
    corner_exp[1] = 6'b100100;
    corner_exp[2] = 6'b100010;
    corner_exp[3] = 6'b100001;
    corner_exp[4] = 6'b110000;
    corner_exp[5] = 6'b000000;
    c_start    = 1'b1;
    c_relu_sel = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      c_start = 1'b0;
      check("corner_ctrl", {26'd0, corner_ctrl()}, {26'd0, corner_exp[c]});
      if (c < 2) check("corner_in_addr", {31'd0, c_in_addr}, 32'd0);
      if (c == 3) check("corner_out_idx", {31'd0, c_out_idx}, 32'd0);
      check("corner_act_fn", {31'd0, c_activation_function}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_layer_ctrl.md
Name: neuron_layer_ctrl

Overview:
Sequencer for one fully-connected layer built from a shared MAC accumulator followed by the bias-add/activation stage.
- For each neuron in turn it:
  - clears the accumulator;
  - streams input/weight addresses;
  - waits for the MAC pipeline to drain;
  - triggers the bias+activation stage;
  - presents the result index downstream under a valid/ready handshake.
- Sits between the network top-level FSM (start/done) and the neuron datapath and weight/input memories.

Parameters:
- NUM_INPUTS, 784, inputs per neuron (>=1).
- NUM_NEURONS, 10, neurons in the layer (>=1).
- MAC_LAT, 2, cycles from the last acc_en until the accumulator value is stable (>=0).
- ACT_LAT, 1, cycles from act_en until the activation-stage output is registered (>=1).
- IA_W, max(1,$clog2(NUM_INPUTS)), in_addr width.
- NI_W, max(1,$clog2(NUM_NEURONS)), neuron index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- relu_sel  in  1  1 = ReLU for this layer, 0 = none; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse after the last neuron is handed off.
- in_addr  out  IA_W  input/weight column address.
- neuron_idx  out  NI_W  current neuron (weight row).
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate the product at in_addr.
- act_en  out  1  capture bias+activation result.
- activation_function  out  1  latched relu_sel, held stable for the whole layer.
- out_valid  out  1  result for out_idx is available.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  NI_W  neuron index of the presented result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; every output = 0, including activation_function and all indices. rst dominates start.
- States and transitions:
  - IDLE: start=1 -> latch relu_sel, neuron_idx=0 -> CLEAR.
  - CLEAR: 1 cycle. acc_clr=1, in_addr=0 -> ACCUM.
  - ACCUM: exactly NUM_INPUTS cycles. acc_en=1; in_addr = 0..NUM_INPUTS-1, incrementing every cycle. At in_addr==NUM_INPUTS-1 -> DRAIN, or -> ACT when MAC_LAT=0.
  - DRAIN: MAC_LAT cycles. All strobes low -> ACT.
  - ACT: ACT_LAT cycles. act_en=1 in the first cycle only -> EMIT.
  - EMIT: out_valid=1, out_idx=neuron_idx, both held until out_ready=1.
    - On the handshake cycle with neuron_idx==NUM_NEURONS-1 -> DONE.
    - Otherwise neuron_idx++ -> CLEAR.
  - DONE: 1 cycle. done=1 -> IDLE; busy drops the next cycle.
- Latency per neuron with out_ready held high: 1+NUM_INPUTS+MAC_LAT+ACT_LAT+1 cycles.
- Layer latency: NUM_NEURONS × per-neuron latency, plus one DONE cycle.
- Handshake rules:
  - out_valid never drops without a handshake.
  - out_idx is stable while out_valid=1.
  - out_ready while out_valid=0 is ignored.
- start while busy is ignored; no queuing.
- start in the DONE cycle is ignored. A start in the IDLE cycle after DONE is accepted.
- relu_sel changes mid-layer have no effect.
- in_addr wraps only via CLEAR (reset to 0); it never counts past NUM_INPUTS-1.
- All outputs are registered. acc_en and in_addr are asserted in the same cycle.

Decomposition:
- Package nn_ctrl_pkg holds:
  - the state enum {IDLE, CLEAR, ACCUM, DRAIN, ACT, EMIT, DONE};
  - a width helper function returning max(1,$clog2(n)).
- One sub-module, lat_counter: a loadable down-counter with load/en/zero flag, reused for the DRAIN and ACT waits.
- All MAC/bias arithmetic stays in the existing datapath; this block has none.

Test Plan:
- Basic layer: NUM_INPUTS=4, NUM_NEURONS=3, MAC_LAT=2, ACT_LAT=1, out_ready=1, start pulsed at edge 0 -> per neuron:
  - acc_clr in cycle 1;
  - acc_en cycles 2-5 with in_addr 0,1,2,3;
  - act_en cycle 8;
  - out_valid cycle 9 with out_idx=0.
  - Repeats every 9 cycles; done pulse in cycle 28.
- Backpressure: same config, out_ready low for 5 cycles at the first EMIT -> out_valid/out_idx=0 held 6 cycles; every later event shifts by exactly 5 cycles; no extra acc_en.
- Activation latch: relu_sel=1 at start, toggled to 0 mid-ACCUM -> activation_function stays 1 until reset or the next start.
- Ignored start: start pulsed during ACCUM and in the DONE cycle -> no state change, no second layer. Start in the following IDLE cycle -> a new layer begins with acc_clr.
- Async reset mid-operation: rst asserted between clock edges during DRAIN of neuron 1 -> all outputs 0 immediately. After release, the block stays IDLE until start.
- Corner: MAC_LAT=0, NUM_INPUTS=1, NUM_NEURONS=1 -> CLEAR, one acc_en with in_addr=0, act_en the next cycle, out_valid the cycle after, then done.
